// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared types and sizes for the BCD conversion arbiter
package bcd_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 20;
  localparam int BCD_W   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    onehot_to_idx = oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational three-way round-robin selector
module rr_pick3
  import bcd_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last_gnt,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  // Search begins one past the previous winner and wraps around.
  always_comb begin
    o_winner = '0;
    case (i_last_gnt)
      2'd0: begin
        if      (i_req[1]) o_winner = 3'b010;
        else if (i_req[2]) o_winner = 3'b100;
        else if (i_req[0]) o_winner = 3'b001;
      end
      2'd1: begin
        if      (i_req[2]) o_winner = 3'b100;
        else if (i_req[0]) o_winner = 3'b001;
        else if (i_req[1]) o_winner = 3'b010;
      end
      default: begin
        if      (i_req[0]) o_winner = 3'b001;
        else if (i_req[1]) o_winner = 3'b010;
        else if (i_req[2]) o_winner = 3'b100;
      end
    endcase
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/bcd_conv_arb.sv
// rtl/bcd_conv_arb.sv - arbitrates three requesters onto one shared BCD engine
module bcd_conv_arb
  import bcd_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_MAX = 8'd100
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_sign,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  eng_start,
  output logic [DATA_W-1:0]     eng_data,
  input  logic                  eng_done,
  input  logic [BCD_W-1:0]      eng_bcd,
  output logic [NUM_REQ-1:0]    res_valid,
  output logic [BCD_W-1:0]      res_bcd,
  output logic                  res_sign,
  output logic                  err_timeout
);

  state_t              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, r_res_valid, r_owner;
  logic                r_eng_start, r_res_sign, r_err_timeout, r_sign;
  logic [DATA_W-1:0]   r_eng_data;
  logic [BCD_W-1:0]    r_res_bcd;
  logic [1:0]          r_last_gnt;
  logic [7:0]          r_cnt;

  logic [NUM_REQ-1:0]  w_winner;
  logic                w_valid;
  logic [1:0]          w_win_idx;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_sign;
  logic                w_grant, w_start, w_capture, w_timeout;

  rr_pick3 u_pick (
    .i_req      (req),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  assign w_win_idx = onehot_to_idx(w_winner);

  always_comb begin
    w_sel_data = req_data[DATA_W-1:0];
    w_sel_sign = req_sign[0];
    case (w_win_idx)
      2'd1: begin
        w_sel_data = req_data[2*DATA_W-1:DATA_W];
        w_sel_sign = req_sign[1];
      end
      2'd2: begin
        w_sel_data = req_data[3*DATA_W-1:2*DATA_W];
        w_sel_sign = req_sign[2];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A completion arriving on the timeout cycle wins over the abort.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == TIMEOUT_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gnt         <= '0;
      r_eng_start   <= 1'b0;
      r_eng_data    <= '0;
      r_res_valid   <= '0;
      r_res_bcd     <= '0;
      r_res_sign    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_cnt         <= '0;
      r_last_gnt    <= 2'd2;
      r_owner       <= '0;
      r_sign        <= 1'b0;
    end else begin
      r_gnt         <= w_grant ? w_winner : '0;
      r_eng_start   <= w_start;
      r_res_valid   <= w_capture ? r_owner : '0;
      r_err_timeout <= w_timeout;
      if (w_grant) begin
        r_eng_data <= w_sel_data;
        r_sign     <= w_sel_sign;
        r_owner    <= w_winner;
        r_last_gnt <= w_win_idx;
      end
      if (w_start)                r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 8'd1;
      if (w_capture) begin
        r_res_bcd  <= eng_bcd;
        r_res_sign <= r_sign;
      end
    end
  end

  assign gnt         = r_gnt;
  assign eng_start   = r_eng_start;
  assign eng_data    = r_eng_data;
  assign res_valid   = r_res_valid;
  assign res_bcd     = r_res_bcd;
  assign res_sign    = r_res_sign;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb/tb_bcd_conv_arb.sv - randomized self-checking bench for bcd_conv_arb
module tb_bcd_conv_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [2:0]  req;
  logic [59:0] req_data;
  logic [2:0]  req_sign;
  logic [2:0]  gnt;
  logic        eng_start;
  logic [19:0] eng_data;
  logic        eng_done;
  logic [23:0] eng_bcd;
  logic [2:0]  res_valid;
  logic [23:0] res_bcd;
  logic        res_sign;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  int          m_last;
  logic [19:0] m_eng_data;
  logic [23:0] m_res_bcd;
  logic        m_res_sign;

  bcd_conv_arb #(.TIMEOUT_MAX(8'd100)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_sign    (req_sign),
    .gnt         (gnt),
    .eng_start   (eng_start),
    .eng_data    (eng_data),
    .eng_done    (eng_done),
    .eng_bcd     (eng_bcd),
    .res_valid   (res_valid),
    .res_bcd     (res_bcd),
    .res_sign    (res_sign),
    .err_timeout (err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph, input logic [2:0] e_gnt, input logic e_start,
                           input logic [2:0] e_rv, input logic e_err);
    chk_eq({ph, ".gnt"},       32'(gnt),         32'(e_gnt));
    chk_eq({ph, ".eng_start"}, 32'(eng_start),   32'(e_start));
    chk_eq({ph, ".eng_data"},  32'(eng_data),    32'(m_eng_data));
    chk_eq({ph, ".res_valid"}, 32'(res_valid),   32'(e_rv));
    chk_eq({ph, ".res_bcd"},   32'(res_bcd),     32'(m_res_bcd));
    chk_eq({ph, ".res_sign"},  32'(res_sign),    32'(m_res_sign));
    chk_eq({ph, ".err"},       32'(err_timeout), 32'(e_err));
  endtask

  function automatic int rr_model(input logic [2:0] r, input int last);
    for (int i = 1; i <= 3; i++) begin
      if (r[(last + i) % 3]) return (last + i) % 3;
    end
    return -1;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] b = '0;
    int x = v % 1000000;
    for (int i = 0; i < 6; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic model_reset();
    m_last     = 2;
    m_eng_data = '0;
    m_res_bcd  = '0;
    m_res_sign = 1'b0;
  endtask

  task automatic idle(input int n, input bit noise);
    req = 3'b000;
    for (int i = 0; i < n; i++) begin
      eng_done = noise ? 1'($urandom) : 1'b0;
      eng_bcd  = 24'($urandom);
      @(posedge sys_clk); #1;
      check_all("idle", 3'b000, 1'b0, 3'b000, 1'b0);
    end
    eng_done = 1'b0;
  endtask

  // Engine answers lat cycles after eng_start rises; lat > 101 means the abort fires first.
  task automatic run_txn(input logic [2:0] r, input logic [59:0] d, input logic [2:0] s,
                         input int lat, input bit hold, input bit noise, input int abort_at);
    int          w;
    int          k_end;
    bit          done_ok;
    logic [2:0]  oh;
    logic        sgn;
    logic [23:0] bcd;
    req      = r;
    req_data = d;
    req_sign = s;
    eng_done = noise ? 1'($urandom) : 1'b0;
    eng_bcd  = 24'($urandom);
    w          = rr_model(r, m_last);
    m_last     = w;
    oh         = 3'b001 << w;
    m_eng_data = d[20*w +: 20];
    sgn        = s[w];
    bcd        = to_bcd(int'(m_eng_data));
    done_ok    = (lat <= 101);
    k_end      = done_ok ? 3 + lat : 103;
    for (int k = 1; k <= k_end; k++) begin
      @(posedge sys_clk); #1;
      if (done_ok && k == 2 + lat) begin
        m_res_bcd  = bcd;
        m_res_sign = sgn;
      end
      check_all("txn", (k == 1) ? oh : 3'b000, (k == 2),
                (done_ok && k == 2 + lat) ? oh : 3'b000, (!done_ok && k == 103));
      if (k == abort_at) begin
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async", 3'b000, 1'b0, 3'b000, 1'b0);
        req      = 3'b000;
        eng_done = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        eng_done  = 1'b1;
        eng_bcd   = 24'($urandom);
        @(posedge sys_clk); #1;
        check_all("late_done", 3'b000, 1'b0, 3'b000, 1'b0);
        eng_done = 1'b0;
        return;
      end
      if (k < k_end) begin
        req = hold ? r : (noise ? 3'($urandom) : 3'b000);
        if (done_ok && k + 1 == 2 + lat)
          eng_done = 1'b1;
        else if (noise && (k + 1 == 2 || (done_ok && k + 1 == 3 + lat)))
          eng_done = 1'($urandom);
        else
          eng_done = 1'b0;
        eng_bcd = (k + 1 == 2 + lat) ? bcd : 24'($urandom);
      end
    end
    eng_done = 1'b0;
  endtask

  function automatic logic [59:0] rand_data();
    logic [59:0] d;
    d[31:0]  = $urandom;
    d[59:32] = 28'($urandom);
    return d;
  endfunction

  initial begin
    logic [59:0] d;
    logic [2:0]  r;
    int          lat;
    sys_rst_n = 1'b0;
    req       = 3'b000;
    req_data  = '0;
    req_sign  = 3'b000;
    eng_done  = 1'b0;
    eng_bcd   = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_all("reset", 3'b000, 1'b0, 3'b000, 1'b0);
    sys_rst_n = 1'b1;
    idle(2, 0);

    d = rand_data();
    d[19:0] = 20'd12345;
    run_txn(3'b001, d, 3'b000, 22, 0, 0, 0);
    chk_eq("single.res_bcd", 32'(res_bcd), 32'h012345);

    for (int i = 0; i < 3; i++) run_txn(3'b111, rand_data(), 3'($urandom), 5, 1, 0, 0);
    idle(1, 0);

    run_txn(3'b111, rand_data(), 3'($urandom), 1000, 0, 0, 0);
    run_txn(3'b111, rand_data(), 3'($urandom), 3, 0, 0, 0);
    run_txn(3'b010, rand_data(), 3'($urandom), 101, 0, 0, 0);
    run_txn(3'b010, rand_data(), 3'($urandom), 102, 0, 0, 0);

    run_txn(3'b001, rand_data(), 3'($urandom), 10, 0, 1, 0);
    idle(3, 1);

    run_txn(3'b010, rand_data(), 3'($urandom), 1000, 0, 0, 10);
    idle(2, 1);
    run_txn(3'b111, rand_data(), 3'($urandom), 4, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      r = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       lat = 100;
          1:       lat = 101;
          2:       lat = 102;
          default: lat = 1000;
        endcase
      end else begin
        lat = $urandom_range(1, 30);
      end
      run_txn(r, rand_data(), 3'($urandom), lat, 1'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
